// File: rtl/diff_comparator_if.sv
// Result handshake between the comparator window counter and its consumer.
interface diff_comparator_if #(
    parameter int unsigned CNT_W = 5
) ();
    logic [CNT_W-1:0] ones_count;
    logic             count_valid;
    logic             count_ready;

    modport master (output ones_count, output count_valid, input count_ready);
    modport slave  (input ones_count, input count_valid, output count_ready);
endinterface

// File: rtl/diff_comparator.sv
// Clocked differential comparator with hysteresis, common-mode monitor and
// windowed ones counter delivered over a valid/ready handshake.
module diff_comparator #(
    parameter int unsigned WIN     = 16,
    parameter int unsigned CNT_W   = $clog2(WIN + 1),
    parameter real         OFFSET  = 0.0,
    parameter real         HYST    = 0.01,
    parameter real         VCM_MIN = 0.2,
    parameter real         VCM_MAX = 0.8
) (
    input  logic              clk,
    input  logic              rst,
    input  real               vin,
    input  real               vinb,
    input  real               vssana,
    input  logic              en,
    diff_comparator_if.master cnt_bus,
    output logic              dout,
    output logic              overrun,
    output logic              cm_err
);
    localparam real TH_HI = OFFSET + HYST / 2.0;
    localparam real TH_LO = OFFSET - HYST / 2.0;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_nxt;
    logic             sample;
    real              vd, vcm;
    logic             dout_nxt, cm_err_nxt, overrun_nxt, valid_nxt, valid, xfer;
    logic [CNT_W-1:0] cnt, cnt_nxt, acc, acc_nxt, count, count_nxt, result;

    // Next-state, decision and window accounting
    always_comb begin
        state_nxt   = state;
        sample      = 1'b0;
        vd          = vin - vinb;
        vcm         = (vin + vinb) / 2.0 - vssana;
        dout_nxt    = dout;
        cm_err_nxt  = cm_err;
        overrun_nxt = overrun;
        valid_nxt   = valid;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        count_nxt   = count;
        result      = '0;
        xfer        = valid && cnt_bus.count_ready;

        case (state)
            IDLE:    if (en)  state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The edge that enters RUN already takes a decision
        sample = (state_nxt == RUN);

        if (xfer) valid_nxt = 1'b0;

        if (sample) begin
            if (!dout && (vd > TH_HI))      dout_nxt = 1'b1;
            else if (dout && (vd < TH_LO))  dout_nxt = 1'b0;
            cm_err_nxt = (vcm < VCM_MIN) || (vcm > VCM_MAX);
            result     = acc + CNT_W'(dout_nxt);
            if (cnt == CNT_W'(WIN - 1)) begin
                cnt_nxt = '0;
                acc_nxt = '0;
                if (!valid || xfer) begin
                    count_nxt = result;
                    valid_nxt = 1'b1;
                end else begin
                    overrun_nxt = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
                acc_nxt = result;
            end
        end else begin
            // Leaving RUN throws away any partial window
            cnt_nxt = '0;
            acc_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dout    <= 1'b0;
            cm_err  <= 1'b0;
            overrun <= 1'b0;
            valid   <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            dout    <= dout_nxt;
            cm_err  <= cm_err_nxt;
            overrun <= overrun_nxt;
            valid   <= valid_nxt;
            cnt     <= cnt_nxt;
            acc     <= acc_nxt;
            count   <= count_nxt;
        end
    end

    assign cnt_bus.ones_count  = count;
    assign cnt_bus.count_valid = valid;
endmodule

// File: tb/tb_diff_comparator.sv
// Scoreboard bench for diff_comparator: window results queued at stimulus
// time, popped and compared by a monitor on each handshake transfer.
module tb_diff_comparator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    real  vin = 0.0, vinb = 0.0, vssana = 0.0;
    logic dout, overrun, cm_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    diff_comparator_if #(.CNT_W(5)) bus ();

    diff_comparator #(.WIN(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .vin     (vin),
        .vinb    (vinb),
        .vssana  (vssana),
        .en      (en),
        .cnt_bus (bus),
        .dout    (dout),
        .overrun (overrun),
        .cm_err  (cm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_v(input real p, input real n);
        vin  = p;
        vinb = n;
    endtask

    // Monitor: a transfer happens on the coming edge when valid and ready
    always @(negedge clk) begin
        if (!rst && bus.count_valid && bus.count_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0d expected none", bus.ones_count);
            end else begin
                check("sb_ones_count", 32'(bus.ones_count), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.count_ready = 1'b1;
        #3;
        check("rst_dout",    32'(dout), 0);
        check("rst_valid",   32'(bus.count_valid), 0);
        check("rst_count",   32'(bus.ones_count), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_cm_err",  32'(cm_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Steady positive input for one full window
        set_v(0.6, 0.4);
        en = 1'b1;
        exp_q.push_back(16);
        tick(1);
        check("basic_dout_edge1", 32'(dout), 1);
        tick(15);
        check("basic_valid", 32'(bus.count_valid), 1);
        check("basic_cm_err", 32'(cm_err), 0);
        en = 1'b0;
        tick(1);
        check("basic_valid_cleared", 32'(bus.count_valid), 0);

        // Hysteresis band edges, then drop en after 5 decisions
        en = 1'b1;
        set_v(-0.004, 0.0); tick(1); check("hyst_m004", 32'(dout), 1);
        set_v(-0.005, 0.0); tick(1); check("hyst_eq_lo", 32'(dout), 1);
        set_v(-0.006, 0.0); tick(1); check("hyst_m006", 32'(dout), 0);
        set_v(0.005, 0.0);  tick(1); check("hyst_eq_hi", 32'(dout), 0);
        set_v(0.006, 0.0);  tick(1); check("hyst_p006", 32'(dout), 1);
        en = 1'b0;
        tick(1);
        en = 1'b1;
        exp_q.push_back(10);
        set_v(0.55, 0.45); tick(10);
        set_v(0.45, 0.55); tick(5);
        check("fresh_no_early", 32'(bus.count_valid), 0);
        tick(1);
        check("fresh_valid", 32'(bus.count_valid), 1);
        en = 1'b0;
        tick(1);

        // Common-mode monitor, and hold while idle
        en = 1'b1;
        set_v(0.1, 0.1); tick(1); check("cm_low", 32'(cm_err), 1);
        set_v(0.5, 0.5); tick(1); check("cm_ok", 32'(cm_err), 0);
        en = 1'b0;
        set_v(0.1, 0.1); tick(1); check("cm_hold_idle", 32'(cm_err), 0);

        // Consumer stalls through two windows; third completes on transfer edge
        bus.count_ready = 1'b0;
        en = 1'b1;
        exp_q.push_back(16);
        set_v(0.55, 0.45); tick(16);
        check("ovr_valid_a", 32'(bus.count_valid), 1);
        check("ovr_flag_a", 32'(overrun), 0);
        tick(8);
        set_v(0.45, 0.55); tick(8);
        check("ovr_flag_b", 32'(overrun), 1);
        check("ovr_kept_a", 32'(bus.ones_count), 16);
        exp_q.push_back(4);
        set_v(0.55, 0.45); tick(4);
        set_v(0.45, 0.55); tick(11);
        bus.count_ready = 1'b1;
        tick(1);
        check("ovr_valid_c", 32'(bus.count_valid), 1);
        check("ovr_count_c", 32'(bus.ones_count), 4);
        en = 1'b0;
        tick(1);
        check("ovr_drained", 32'(bus.count_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);

        // Async reset mid-window
        en = 1'b1;
        set_v(0.55, 0.45);
        tick(7);
        #2 rst = 1'b1;
        #1;
        check("arst_dout",    32'(dout), 0);
        check("arst_count",   32'(bus.ones_count), 0);
        check("arst_valid",   32'(bus.count_valid), 0);
        check("arst_overrun", 32'(overrun), 0);
        check("arst_cm_err",  32'(cm_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(16);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.count_valid) begin
                n = i;
                break;
            end
        end
        check("arst_window_len", 32'(n), 16);
        en = 1'b0;
        tick(2);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/diff_comparator.md
DIFF_COMPARATOR -- requirements
Module: diff_comparator

Interface
REQ-001 Parameter WIN, default 16; number of decisions per counting window (2..255).
REQ-002 Parameter CNT_W, default $clog2(WIN+1); width of ones_count.
REQ-003 Parameter OFFSET (real), default 0.0; decision threshold on vin-vinb, in V.
REQ-004 Parameter HYST (real), default 0.01; total hysteresis band, in V.
REQ-005 Parameters VCM_MIN / VCM_MAX (real), defaults 0.2 / 0.8; allowed common-mode window relative to vssana, in V.
REQ-006 clk  input  1  sampling clock; all state changes on posedge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 vin  input  real  positive output voltage of the upstream resistor load.
REQ-009 vinb  input  real  negative output voltage of the upstream resistor load.
REQ-010 vssana  input  real  analog ground reference.
REQ-011 en  input  1  sampling enable.
REQ-012 count_ready  input  1  consumer accepts ones_count.
REQ-013 dout  output  1  registered comparator decision.
REQ-014 ones_count  output  CNT_W  number of 1 decisions in the last completed window.
REQ-015 count_valid  output  1  ones_count holds an untransferred result.
REQ-016 overrun  output  1  sticky flag: a window result was dropped.
REQ-017 cm_err  output  1  last sampled common mode was out of range.

Function
REQ-018 Differential vd = vin - vinb; common mode vcm = (vin+vinb)/2 - vssana; both are evaluated only at posedge clk while sampling.
REQ-019 FSM states: IDLE (en=0) and RUN (en=1); IDLE->RUN on posedge with en=1, RUN->IDLE on posedge with en=0; reset enters IDLE.
REQ-020 In RUN, each posedge is one decision: if dout=0 and vd > OFFSET+HYST/2, dout<=1; if dout=1 and vd < OFFSET-HYST/2, dout<=0; otherwise dout holds.
REQ-021 Equality with a threshold does not toggle dout (strict comparisons).
REQ-022 Latency: dout reflects vin/vinb sampled at the same edge, visible one cycle after the input changes.
REQ-023 In RUN, cm_err <= (vcm < VCM_MIN) or (vcm > VCM_MAX) each posedge; cm_err holds in IDLE.
REQ-024 Internal sample counter 0..WIN-1 and accumulator count the new (post-update) dout value per decision.
REQ-025 On the edge sampling the WIN-th decision, the window completes: result = acc + new dout, counter and acc clear to 0 (wrap), next window starts the following edge with no gap.
REQ-026 Handshake: transfer occurs at posedge where count_valid=1 and count_ready=1; count_valid clears after transfer unless a new result loads at the same edge.
REQ-027 Completion with count_valid=0, or with a transfer at the same edge: ones_count <= result, count_valid <= 1.
REQ-028 Completion with count_valid=1 and count_ready=0: result dropped, ones_count unchanged, overrun <= 1.
REQ-029 overrun is cleared only by rst.
REQ-030 In IDLE, sample counter and acc are 0, dout holds, and any pending ones_count/count_valid is retained and still transferable.
REQ-031 RUN->IDLE mid-window discards the partial window; the next RUN entry starts a fresh window.
REQ-032 ones_count range is 0..WIN; CNT_W must hold WIN without overflow.

Reset
REQ-033 rst=1 immediately forces dout=0, ones_count=0, count_valid=0, overrun=0, cm_err=0, counter=0, acc=0, state IDLE, regardless of clk.
REQ-034 Reset asserted mid-window or with a pending result discards both; sampling resumes at the first posedge after rst=0 with en=1.

Verification
REQ-035 vin=0.6, vinb=0.4, vssana=0, en=1 for 16 edges -> dout=1 from edge 1, count_valid=1 with ones_count=16 after edge 16, cm_err=0.
REQ-036 dout=1, vd=-0.004 -> dout stays 1; vd=-0.006 -> dout=0 at next edge; vd=+0.005 -> stays 0; vd=+0.006 -> 1.
REQ-037 count_ready=0 through two full windows -> first result retained, overrun=1 after edge 32; count_ready=1 at edge 48 (completion) -> third result loaded, count_valid stays 1.
REQ-038 rst pulse at edge 7 of a window -> all outputs 0 immediately; with en=1, next count_valid occurs 16 edges after release.
REQ-039 vin=vinb=0.1 V -> cm_err=1 at next edge; vin=vinb=0.5 V -> cm_err=0.
REQ-040 en dropped after 5 decisions then raised -> partial window discarded; next result counts 16 fresh decisions.
